// File: rtl/soc_mem_pkg.sv
// rtl/soc_mem_pkg.sv - shared types and defaults for the SOC memory arbiter
package soc_mem_pkg;

  localparam int SOC_MEM_DEPTH  = 64;
  localparam int SOC_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_LS
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_LS
  } grant_t;

endpackage

// File: rtl/soc_mem_arbiter_if.sv
// rtl/soc_mem_arbiter_if.sv - requester and memory signal bundle for soc_mem_arbiter
interface soc_mem_arbiter_if
  import soc_mem_pkg::*;
#(
  parameter int MEM_DEPTH  = SOC_MEM_DEPTH,
  parameter int DATA_WIDTH = SOC_DATA_WIDTH
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  // Instruction-fetch requester
  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic                  if_valid_data;
  logic [DATA_WIDTH-1:0] if_rdata;

  // Load/store requester
  logic                  ls_req_valid;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  ls_ready;
  logic                  ls_valid_data;
  logic [DATA_WIDTH-1:0] ls_rdata;

  // Memory side
  logic                  mem_req_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_valid_data;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  err_spurious;

  // Environment side: requesters and the memory
  modport master (
    output if_req_valid, if_addr,
    input  if_ready, if_valid_data, if_rdata,
    output ls_req_valid, ls_we, ls_addr, ls_wdata,
    input  ls_ready, ls_valid_data, ls_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_valid_data, mem_rdata,
    input  err_spurious
  );

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr,
    output if_ready, if_valid_data, if_rdata,
    input  ls_req_valid, ls_we, ls_addr, ls_wdata,
    output ls_ready, ls_valid_data, ls_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_valid_data, mem_rdata,
    output err_spurious
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker with last-grant memory
module rr_arb2
  import soc_mem_pkg::*;
(
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   req_if_i,
  input  logic   req_ls_i,
  input  logic   update_i,
  output logic   gnt_valid_o,
  output grant_t gnt_o
);

  grant_t last_grant_q;

  // Pick a winner; on a tie the side that did not win last time goes first
  always_comb begin
    gnt_valid_o = req_if_i | req_ls_i;
    gnt_o       = GNT_IF;
    if (req_if_i && req_ls_i) begin
      gnt_o = (last_grant_q == GNT_LS) ? GNT_IF : GNT_LS;
    end else if (req_ls_i) begin
      gnt_o = GNT_LS;
    end
  end

  // Remember the winner only when the arbiter actually issues the grant
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= GNT_LS;
    end else if (update_i && gnt_valid_o) begin
      last_grant_q <= gnt_o;
    end
  end

endmodule

// File: rtl/soc_mem_arbiter.sv
// rtl/soc_mem_arbiter.sv - single-outstanding round-robin arbiter for the SOC memory
module soc_mem_arbiter
  import soc_mem_pkg::*;
#(
  parameter int MEM_DEPTH  = SOC_MEM_DEPTH,
  parameter int DATA_WIDTH = SOC_DATA_WIDTH
)(
  input  logic              clk,
  input  logic              reset,
  soc_mem_arbiter_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  arb_state_t            state_q, state_d;
  logic                  if_ready_q, if_ready_d;
  logic                  ls_ready_q, ls_ready_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_valid_data_q, if_valid_data_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  ls_valid_data_q, ls_valid_data_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  ls_write_q, ls_write_d;
  logic                  err_q, err_d;

  logic                  arb_update;
  logic                  gnt_valid;
  grant_t                gnt;

  // Requests only compete while idle; the picker state advances on each grant
  rr_arb2 u_arb (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_if_i    (bus.if_req_valid),
    .req_ls_i    (bus.ls_req_valid),
    .update_i    (arb_update),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt)
  );

  // Next-state and registered-output logic for the grant/wait FSM
  always_comb begin
    state_d         = state_q;
    if_ready_d      = 1'b0;
    ls_ready_d      = 1'b0;
    mem_req_valid_d = 1'b0;
    if_valid_data_d = 1'b0;
    ls_valid_data_d = 1'b0;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    if_rdata_d      = if_rdata_q;
    ls_rdata_d      = ls_rdata_q;
    ls_write_d      = ls_write_q;
    err_d           = err_q;
    arb_update      = 1'b0;

    case (state_q)
      IDLE: begin
        // A completion with nothing outstanding is dropped and flagged
        if (bus.mem_valid_data) begin
          err_d = 1'b1;
        end
        if (gnt_valid) begin
          arb_update      = 1'b1;
          mem_req_valid_d = 1'b1;
          if (gnt == GNT_IF) begin
            if_ready_d  = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            state_d     = WAIT_IF;
          end else begin
            ls_ready_d  = 1'b1;
            mem_we_d    = bus.ls_we;
            mem_addr_d  = bus.ls_addr;
            mem_wdata_d = bus.ls_wdata;
            ls_write_d  = bus.ls_we;
            state_d     = WAIT_LS;
          end
        end
      end
      WAIT_IF: begin
        if (bus.mem_valid_data) begin
          if_valid_data_d = 1'b1;
          if_rdata_d      = bus.mem_rdata;
          state_d         = IDLE;
        end
      end
      WAIT_LS: begin
        if (bus.mem_valid_data) begin
          ls_valid_data_d = 1'b1;
          // Write acknowledgements carry no data
          ls_rdata_d      = ls_write_q ? '0 : bus.mem_rdata;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides any concurrent completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      if_ready_q      <= 1'b0;
      ls_ready_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      if_valid_data_q <= 1'b0;
      if_rdata_q      <= '0;
      ls_valid_data_q <= 1'b0;
      ls_rdata_q      <= '0;
      ls_write_q      <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      if_ready_q      <= if_ready_d;
      ls_ready_q      <= ls_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      if_valid_data_q <= if_valid_data_d;
      if_rdata_q      <= if_rdata_d;
      ls_valid_data_q <= ls_valid_data_d;
      ls_rdata_q      <= ls_rdata_d;
      ls_write_q      <= ls_write_d;
      err_q           <= err_d;
    end
  end

  assign bus.if_ready      = if_ready_q;
  assign bus.ls_ready      = ls_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.if_valid_data = if_valid_data_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.ls_valid_data = ls_valid_data_q;
  assign bus.ls_rdata      = ls_rdata_q;
  assign bus.err_spurious  = err_q;

endmodule
